// File: rtl/inst_fetch_buffer_pkg.sv
// inst_fetch_buffer_pkg: shared constants and the packed bundle entry layout for the fetch buffer.
package inst_fetch_buffer_pkg;
  localparam int FB_DEPTH = 8;
  localparam int EXC_W = 7;
  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  typedef struct packed {
    logic [31:0]      pc0;
    logic [31:0]      inst0;
    logic [31:0]      inst1;
    logic [31:0]      pc_next;
    logic             pc_taken;
    logic [31:0]      badv;
    logic [1:0]       excp_flag;
    logic [EXC_W-1:0] exception;
    logic [1:0]       priv_flag;
    logic [1:0]       branch_flag;
  } fb_entry_t;
  localparam int FB_W = $bits(fb_entry_t);
  localparam fb_entry_t FB_DEFAULT = '{inst0: INST_NOP, inst1: INST_NOP, default: '0};
endpackage

// File: rtl/inst_fetch_buffer_if.sv
// inst_fetch_buffer_if: IF-side write bus and ID-side read bus of the fetch buffer.
interface inst_fetch_buffer_if;
  import inst_fetch_buffer_pkg::*;
  logic             if_valid;
  logic             if_allowin;
  logic [1:0]       if_valid_mask;
  logic [31:0]      if_pc0;
  logic [31:0]      if_inst0;
  logic [31:0]      if_inst1;
  logic [31:0]      if_pc_next;
  logic             if_pc_taken;
  logic [31:0]      if_badv;
  logic [1:0]       if_excp_flag;
  logic [EXC_W-1:0] if_exception;
  logic [1:0]       if_priv_flag;
  logic [1:0]       if_branch_flag;
  logic             id_allowin;
  logic             id_readygo;
  logic [31:0]      fifo_id_pc0;
  logic [31:0]      fifo_id_pc1;
  logic [31:0]      fifo_id_inst0;
  logic [31:0]      fifo_id_inst1;
  logic [31:0]      fifo_id_pc_next;
  logic             fifo_id_pc_taken;
  logic [31:0]      fifo_id_badv;
  logic [1:0]       fifo_id_excp_flag;
  logic [EXC_W-1:0] fifo_id_exception;
  logic [1:0]       fifo_id_priv_flag;
  logic [1:0]       fifo_id_branch_flag;
  modport master (
    output if_valid, if_valid_mask, if_pc0, if_inst0, if_inst1, if_pc_next, if_pc_taken,
           if_badv, if_excp_flag, if_exception, if_priv_flag, if_branch_flag, id_allowin,
    input  if_allowin, id_readygo, fifo_id_pc0, fifo_id_pc1, fifo_id_inst0, fifo_id_inst1,
           fifo_id_pc_next, fifo_id_pc_taken, fifo_id_badv, fifo_id_excp_flag,
           fifo_id_exception, fifo_id_priv_flag, fifo_id_branch_flag
  );
  modport slave (
    input  if_valid, if_valid_mask, if_pc0, if_inst0, if_inst1, if_pc_next, if_pc_taken,
           if_badv, if_excp_flag, if_exception, if_priv_flag, if_branch_flag, id_allowin,
    output if_allowin, id_readygo, fifo_id_pc0, fifo_id_pc1, fifo_id_inst0, fifo_id_inst1,
           fifo_id_pc_next, fifo_id_pc_taken, fifo_id_badv, fifo_id_excp_flag,
           fifo_id_exception, fifo_id_priv_flag, fifo_id_branch_flag
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: bundle-granular FIFO decoupling IF from ID; cleared by flush or reset.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic aclk,
  input logic aresetn,
  input logic flush,
  inst_fetch_buffer_if.slave bus
);
  logic [FB_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_empty, w_full, w_enq, w_deq;
  fb_entry_t        w_wdata, w_head;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (PTR_W+1)'(DEPTH);
  assign w_enq   = bus.if_valid && !w_full && !flush && |bus.if_valid_mask;
  assign w_deq   = !w_empty && bus.id_allowin && !flush;
  // Invalid slots are stored as NOPs with their per-slot flags cleared.
  always_comb begin
    w_wdata             = '0;
    w_wdata.pc0         = bus.if_pc0;
    w_wdata.inst0       = bus.if_valid_mask[0] ? bus.if_inst0 : INST_NOP;
    w_wdata.inst1       = bus.if_valid_mask[1] ? bus.if_inst1 : INST_NOP;
    w_wdata.pc_next     = bus.if_pc_next;
    w_wdata.pc_taken    = bus.if_pc_taken;
    w_wdata.badv        = bus.if_badv;
    w_wdata.excp_flag   = bus.if_excp_flag & bus.if_valid_mask;
    w_wdata.exception   = bus.if_exception;
    w_wdata.priv_flag   = bus.if_priv_flag & bus.if_valid_mask;
    w_wdata.branch_flag = bus.if_branch_flag & bus.if_valid_mask;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_deq);
    end
  end
  always_ff @(posedge aclk) begin
    if (aresetn && w_enq) r_mem[r_wptr] <= w_wdata;
  end
  assign w_head                  = w_empty ? FB_DEFAULT : fb_entry_t'(r_mem[r_rptr]);
  assign bus.if_allowin          = !w_full;
  assign bus.id_readygo          = !w_empty;
  assign bus.fifo_id_pc0         = w_head.pc0;
  assign bus.fifo_id_pc1         = w_empty ? 32'h0 : w_head.pc0 + 32'd4;
  assign bus.fifo_id_inst0       = w_head.inst0;
  assign bus.fifo_id_inst1       = w_head.inst1;
  assign bus.fifo_id_pc_next     = w_head.pc_next;
  assign bus.fifo_id_pc_taken    = w_head.pc_taken;
  assign bus.fifo_id_badv        = w_head.badv;
  assign bus.fifo_id_excp_flag   = w_head.excp_flag;
  assign bus.fifo_id_exception   = w_head.exception;
  assign bus.fifo_id_priv_flag   = w_head.priv_flag;
  assign bus.fifo_id_branch_flag = w_head.branch_flag;
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed vector table plus hand-written flush/reset/stream sequences.
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;
  inst_fetch_buffer_if bus();
  inst_fetch_buffer dut (.aclk(aclk), .aresetn(aresetn), .flush(flush), .bus(bus));
  always #5 aclk = ~aclk;
  typedef struct {
    logic        v;
    logic [1:0]  m;
    logic [31:0] pc, i0, i1;
    logic [1:0]  bf;
    logic        ida;
    logic        rg, al;
    logic [31:0] epc, ei0, ei1;
    logic [1:0]  ebf;
  } vec_t;
  vec_t tv[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  function automatic vec_t mk(logic v, logic [1:0] m, logic [31:0] pc, i0, i1, logic [1:0] bf,
                              logic ida, logic rg, al, logic [31:0] epc, ei0, ei1, logic [1:0] ebf);
    mk = '{v, m, pc, i0, i1, bf, ida, rg, al, epc, ei0, ei1, ebf};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic drive(logic v, logic [1:0] m, logic [31:0] pc, i0, i1, logic [1:0] bf, logic ida);
    bus.if_valid       = v;
    bus.if_valid_mask  = m;
    bus.if_pc0         = pc;
    bus.if_inst0       = i0;
    bus.if_inst1       = i1;
    bus.if_pc_next     = pc + 32'd8;
    bus.if_pc_taken    = 1'b1;
    bus.if_badv        = pc;
    bus.if_excp_flag   = bf;
    bus.if_exception   = 7'h0d;
    bus.if_priv_flag   = bf;
    bus.if_branch_flag = bf;
    bus.id_allowin     = ida;
  endtask
  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask
  task automatic chk_empty(string tag);
    chk({tag, "_readygo"}, 64'(bus.id_readygo), 64'd0);
    chk({tag, "_allowin"}, 64'(bus.if_allowin), 64'd1);
    chk({tag, "_pc0"}, 64'(bus.fifo_id_pc0), 64'd0);
    chk({tag, "_inst0"}, 64'(bus.fifo_id_inst0), 64'(INST_NOP));
    chk({tag, "_inst1"}, 64'(bus.fifo_id_inst1), 64'(INST_NOP));
    chk({tag, "_flags"}, 64'({bus.fifo_id_branch_flag, bus.fifo_id_excp_flag, bus.fifo_id_exception}), 64'd0);
  endtask
  initial begin
    int sent, got;
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0);
    step();
    step();
    aresetn = 1'b1;
    chk_empty("reset");
    tv.push_back(mk(1, 2'b11, 32'h1c000000, 32'h02800421, 32'h02800842, 2'b11, 0,
                    1, 1, 32'h1c000000, 32'h02800421, 32'h02800842, 2'b11));
    tv.push_back(mk(1, 2'b01, 32'h1c000008, 32'h02800c63, 32'h12345678, 2'b11, 1,
                    1, 1, 32'h1c000008, 32'h02800c63, INST_NOP, 2'b01));
    tv.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 1, 0, INST_NOP, INST_NOP, 2'b00));
    tv.push_back(mk(1, 2'b00, 32'h1c000010, 32'h1, 32'h2, 2'b11, 1, 0, 1, 0, INST_NOP, INST_NOP, 2'b00));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 2'b11, 32'h100 + 8*i, 32'hb00 + i, 32'hc00 + i, 2'b10, 0,
                      1, i < 7, 32'h100, 32'hb00, 32'hc00, 2'b10));
    tv.push_back(mk(1, 2'b11, 32'h999, 32'h999, 32'h999, 2'b11, 1, 1, 1, 32'h108, 32'hb01, 32'hc01, 2'b10));
    for (int j = 0; j < 7; j++)
      tv.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 1, j < 6, 1,
                      j < 6 ? 32'h110 + 8*j : 32'h0, j < 6 ? 32'hb02 + j : INST_NOP,
                      j < 6 ? 32'hc02 + j : INST_NOP, j < 6 ? 2'b10 : 2'b00));
    foreach (tv[k]) begin
      drive(tv[k].v, tv[k].m, tv[k].pc, tv[k].i0, tv[k].i1, tv[k].bf, tv[k].ida);
      step();
      chk($sformatf("v%0d_readygo", k), 64'(bus.id_readygo), 64'(tv[k].rg));
      chk($sformatf("v%0d_allowin", k), 64'(bus.if_allowin), 64'(tv[k].al));
      chk($sformatf("v%0d_pc0", k), 64'(bus.fifo_id_pc0), 64'(tv[k].epc));
      chk($sformatf("v%0d_pc1", k), 64'(bus.fifo_id_pc1), tv[k].rg ? 64'(tv[k].epc + 32'd4) : 64'd0);
      chk($sformatf("v%0d_inst0", k), 64'(bus.fifo_id_inst0), 64'(tv[k].ei0));
      chk($sformatf("v%0d_inst1", k), 64'(bus.fifo_id_inst1), 64'(tv[k].ei1));
      chk($sformatf("v%0d_bflag", k), 64'(bus.fifo_id_branch_flag), 64'(tv[k].ebf));
      chk($sformatf("v%0d_eflag", k), 64'(bus.fifo_id_excp_flag), 64'(tv[k].ebf));
      chk($sformatf("v%0d_pflag", k), 64'(bus.fifo_id_priv_flag), 64'(tv[k].ebf));
      chk($sformatf("v%0d_pc_next", k), 64'(bus.fifo_id_pc_next), tv[k].rg ? 64'(tv[k].epc + 32'd8) : 64'd0);
      chk($sformatf("v%0d_exc", k), 64'({bus.fifo_id_pc_taken, bus.fifo_id_exception}),
          tv[k].rg ? 64'h8d : 64'd0);
    end
    sent = 0;
    got = 0;
    for (int c = 0; c < 1000 && got < 20; c++) begin
      drive((sent < 20) && ($urandom_range(0, 1) == 1), 2'b11, 32'h2000 + 16*sent,
            32'ha0000000 | sent, 32'h0, 2'b00, $urandom_range(0, 1) == 1);
      if (bus.id_readygo && bus.id_allowin) begin
        if (q_pc.size() == 0) chk("stream_extra", 64'(bus.fifo_id_pc0), 64'hffffffff_ffffffff);
        else begin
          chk($sformatf("stream%0d_pc0", got), 64'(bus.fifo_id_pc0), 64'(q_pc.pop_front()));
          chk($sformatf("stream%0d_inst0", got), 64'(bus.fifo_id_inst0), 64'(q_in.pop_front()));
        end
        got++;
      end
      if (bus.if_valid && bus.if_allowin) begin
        q_pc.push_back(bus.if_pc0);
        q_in.push_back(bus.if_inst0);
        sent++;
      end
      step();
    end
    chk("stream_count", 64'(got), 64'd20);
    drive(0, 2'b11, 0, 0, 0, 2'b00, 0);
    step();
    chk_empty("stream_end");
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b11, 32'h3000 + 8*i, 32'h5000 + i, 32'h6000, 2'b01, 0);
      step();
    end
    chk("pre_flush_pc0", 64'(bus.fifo_id_pc0), 64'h3000);
    drive(1, 2'b11, 32'h3100, 32'h5100, 32'h6100, 2'b11, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_empty("flush");
    drive(1, 2'b11, 32'h3200, 32'h5200, 32'h6200, 2'b01, 0);
    step();
    chk("post_flush_pc0", 64'(bus.fifo_id_pc0), 64'h3200);
    chk("post_flush_inst0", 64'(bus.fifo_id_inst0), 64'h5200);
    drive(0, 2'b11, 0, 0, 0, 2'b00, 1);
    step();
    chk_empty("post_flush_drain");
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, 32'h4000 + 8*i, 32'h7000 + i, 32'h0, 2'b00, 0);
      step();
    end
    chk("pre_reset_readygo", 64'(bus.id_readygo), 64'd1);
    drive(1, 2'b11, 32'h4100, 32'h7100, 32'h0, 2'b00, 1);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    chk_empty("midreset");
    drive(0, 2'b11, 0, 0, 0, 2'b00, 0);
    step();
    chk_empty("midreset_idle");
    drive(1, 2'b11, 32'h4400, 32'h4444, 32'h0, 2'b10, 0);
    step();
    chk("post_reset_pc0", 64'(bus.fifo_id_pc0), 64'h4400);
    chk("post_reset_inst0", 64'(bus.fifo_id_inst0), 64'h4444);
    chk("post_reset_bflag", 64'(bus.fifo_id_branch_flag), 64'd2);
    drive(0, 2'b11, 0, 0, 0, 2'b00, 1);
    step();
    chk_empty("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
